// File: rtl/shift_frame_sched.sv
// ---------------------------------------------------------------------------
// shift_frame_sched
//
// Round-robin scheduler and sequencer for a parallel-load serial shift
// register datapath. Two requesters offer WIDTH-bit frames; the granted frame
// is loaded into the datapath, shifted out one bit per cycle in the requested
// direction, and the datapath's registered serial output is re-aligned with
// valid/first/last markers for the downstream consumer.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/data/dir  requester handshakes (N = 0, 1); dir=1 is LSB first
//   abort                      cancel the frame in LOAD, SHIFT or DONE
//   sr_load, sr_en_shift       datapath parallel-load / shift-enable controls
//   sr_right_left, sr_data_in  datapath direction and parallel word
//   sr_out                     datapath registered serial output
//   ser_bit/valid/first/last   aligned serial stream to the consumer
//   done, aborted              completion / cancellation pulses
//   busy, grant_id             scheduler activity and current owner
// ---------------------------------------------------------------------------
module shift_frame_sched #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic             abort,
    output logic             sr_load,
    output logic             sr_en_shift,
    output logic             sr_right_left,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic             sr_out,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic             grant_id
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             ser_valid_q;
    logic [CNT_W-1:0] bit_idx_q;
    logic             aborted_q;

    logic st_idle;
    logic st_active;
    logic abort_hit;
    logic win0;
    logic win1;

    assign st_idle   = (state_q == S_IDLE);
    assign st_active = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_DONE);
    assign abort_hit = abort && st_active;

    // Round robin: a lone requester always wins; on a tie the one that did
    // not receive the previous grant wins.
    assign win0 = req0_valid && (!req1_valid || last_grant_q);
    assign win1 = req1_valid && (!req0_valid || !last_grant_q);

    // Ready is qualified with rst_n so that no output is high while reset is
    // held, even though the state register already sits in IDLE.
    assign req0_ready = rst_n && st_idle && win0;
    assign req1_ready = rst_n && st_idle && win1;

    // Datapath controls: an abort kills the strobe in the very cycle it is seen.
    assign sr_load       = (state_q == S_LOAD)  && !abort;
    assign sr_en_shift   = (state_q == S_SHIFT) && !abort;
    assign sr_right_left = dir_q;
    assign sr_data_in    = data_q;

    assign ser_bit   = sr_out;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_valid_q && (bit_idx_q == '0);
    assign ser_last  = ser_valid_q && (bit_idx_q == CNT_LAST);

    assign done     = (state_q == S_DONE) && !abort;
    assign aborted  = aborted_q;
    assign busy     = !st_idle;
    assign grant_id = grant_id_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        data_d       = data_q;
        dir_d        = dir_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;

        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    state_d      = S_LOAD;
                    data_d       = req1_ready ? req1_data : req0_data;
                    dir_d        = req1_ready ? req1_dir : req0_dir;
                    last_grant_d = req1_ready;
                    grant_id_d   = req1_ready;
                end
            end
            S_LOAD: begin
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                // The counter parks on the last index so it never wraps.
                if (bit_cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A cancelled frame returns straight to IDLE, skipping any gap.
        if (abort_hit) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            data_q       <= '0;
            dir_q        <= 1'b0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            ser_valid_q  <= 1'b0;
            bit_idx_q    <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= data_d;
            dir_q        <= dir_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            // The datapath output register lags the shift strobe by one
            // cycle, so valid and the bit index are delayed to match it.
            ser_valid_q  <= sr_en_shift;
            bit_idx_q    <= bit_cnt_q;
            aborted_q    <= abort_hit;
        end
    end

endmodule

// File: doc/shift_frame_sched.md
# shift_frame_sched

Two-requester scheduler and sequencer for the team's parallel-load serial shift register datapath. It arbitrates round-robin between two word sources and drives the datapath's load, shift-enable and direction controls to serialise one WIDTH-bit frame at a time. It also aligns the datapath's registered serial output with valid, first and last markers for the downstream serial consumer.

## Interface
- `WIDTH`, 8: frame width in bits; must equal the datapath width; must be at least 2.
- `GAP_CYCLES`, 0: idle cycles inserted after each completed frame, before the next grant.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  requester has a frame
- `req0_ready` / `req1_ready`  out  1  frame accepted this cycle when ANDed with valid
- `req0_data` / `req1_data`  in  WIDTH  frame word
- `req0_dir` / `req1_dir`  in  1  1 = shift right (LSB first), 0 = shift left (MSB first)
- `abort`  in  1  synchronous cancel of the frame in progress
- `sr_load`  out  1  datapath parallel load
- `sr_en_shift`  out  1  datapath shift enable
- `sr_right_left`  out  1  datapath direction
- `sr_data_in`  out  WIDTH  datapath parallel word
- `sr_out`  in  1  datapath registered serial output
- `ser_bit`, `ser_valid`, `ser_first`, `ser_last`  out  1  serial stream to the consumer
- `done`  out  1  one-cycle pulse on the last bit of a completed frame
- `aborted`  out  1  one-cycle pulse when a frame is cancelled
- `busy`  out  1  state is not IDLE
- `grant_id`  out  1  requester owning the current or most recent frame

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE, GAP.
- IDLE:
  - `reqN_ready` is combinational: IDLE and `reqN_valid` and requester N wins arbitration.
  - Ready is never asserted outside IDLE.
- Arbitration is round-robin on `last_grant`:
  - With a single requester valid, that requester wins.
  - With both valid, the requester that is not `last_grant` wins.
  - `last_grant` updates on accept.
- On accept:
  - Capture the data word and dir.
  - Set `grant_id`.
  - Move to LOAD.
- LOAD (1 cycle):
  - `sr_load`=1.
  - `sr_data_in` = captured word.
  - `sr_right_left` = captured dir.
  - Clear `bit_cnt`.
- SHIFT (WIDTH cycles):
  - `sr_en_shift`=1.
  - `sr_right_left` = captured dir.
  - `bit_cnt` increments each cycle; exit to DONE when `bit_cnt`==WIDTH-1.
- DONE (1 cycle):
  - The last serial bit is presented.
  - `done`=1.
  - Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE.
- `sr_*` outputs are combinational decodes of state. `sr_load` and `sr_en_shift` are never asserted together.
- `sr_data_in` holds the captured word in all states; `sr_right_left` holds the captured dir.
- Serial alignment:
  - `ser_valid` is `sr_en_shift` registered one cycle.
  - `ser_bit` = `sr_out` (combinational passthrough).
  - `ser_first` = `ser_valid` and bit index 0; `ser_last` = `ser_valid` and bit index WIDTH-1.
  - Bit index is a registered copy of `bit_cnt`.
- `abort` in LOAD, SHIFT or DONE:
  - `sr_load` and `sr_en_shift` are gated low in that same cycle.
  - Next state is IDLE; the GAP state is skipped.
  - The `ser_valid` pipeline is cleared next cycle.
  - `aborted` pulses next cycle; `done` is not asserted.
- `abort` in IDLE or GAP is ignored.

## Timing
- Reset:
  - State is IDLE, `bit_cnt`=0, captured word and dir are 0, `last_grant`=1 so req0 wins the first tie.
  - All outputs are 0 except the `sr_data_in`/`sr_right_left` captured values, which are also 0.
- With the accept in cycle 0:
  - Cycle 1 is LOAD.
  - Cycles 2..WIDTH+1 are SHIFT.
  - Cycle WIDTH+2 is DONE.
  - `ser_valid` is high in cycles 3..WIDTH+2.
  - `done` is high in cycle WIDTH+2.
- The earliest next accept is cycle WIDTH+3+GAP_CYCLES.
- Throughput: one WIDTH-bit frame per WIDTH+3+GAP_CYCLES cycles.
- Requester `data` and `dir` are sampled only in the accept cycle; later changes have no effect.
- `busy` deasserts in the first IDLE cycle.
- Reset mid-frame: an immediate return to IDLE with all outputs low. The datapath is reset by the same `rst_n`.

## Test plan
- WIDTH=8, req0 8'hC4 with dir=1, accept at cycle 0:
  - `ser_bit` = 0,0,1,0,0,0,1,1 in cycles 3..10.
  - `ser_first` at 3; `ser_last` and `done` at 10.
  - `busy` low at 11.
- req1 8'hC4 with dir=0:
  - `ser_bit` = 1,1,0,0,0,1,0,0.
  - `grant_id`=1.
  - `sr_right_left`=0 throughout.
- Both valid continuously, with distinct words:
  - Grants alternate req0, req1, req0, req1.
  - Accepts are spaced 11 cycles apart at GAP_CYCLES=0, and 14 apart at GAP_CYCLES=3.
- `abort` in the 3rd SHIFT cycle:
  - `sr_en_shift` is low that cycle.
  - `aborted` pulses next cycle; `done` is never asserted.
  - `ser_valid` is low from the next cycle.
  - The next accept is possible 1 cycle after abort.
- `rst_n` asserted during SHIFT, then released:
  - All outputs go 0 asynchronously.
  - After release, req0 wins the first tie, then the frame completes normally.
- A requester changes `data` the cycle after accept: the serialised bits match the originally accepted word.
